// File: rtl/bip_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bip_loader_pkg
// Purpose  : Command bytes, FSM state encoding and default widths for bip_loader
// Revision : 1.0
// ============================================================================
package bip_loader_pkg;

    localparam int DATA_LENGTH_DEF = 16;
    localparam int ADDR_LENGTH_DEF = 11;

    localparam logic [7:0] CMD_PROG  = 8'h50;
    localparam logic [7:0] CMD_DATA  = 8'h44;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STOP  = 8'h53;
    localparam logic [7:0] CMD_QUERY = 8'h51;

    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] ST_CNT_HI = 4'd1;
    localparam logic [STATE_W-1:0] ST_CNT_LO = 4'd2;
    localparam logic [STATE_W-1:0] ST_W_HI   = 4'd3;
    localparam logic [STATE_W-1:0] ST_W_LO   = 4'd4;
    localparam logic [STATE_W-1:0] ST_WRITE  = 4'd5;
    localparam logic [STATE_W-1:0] ST_A_HI   = 4'd6;
    localparam logic [STATE_W-1:0] ST_A_LO   = 4'd7;
    localparam logic [STATE_W-1:0] ST_RD     = 4'd8;
    localparam logic [STATE_W-1:0] ST_CAP    = 4'd9;
    localparam logic [STATE_W-1:0] ST_TX_HI  = 4'd10;
    localparam logic [STATE_W-1:0] ST_TX_LO  = 4'd11;

endpackage
`default_nettype wire

// File: rtl/loader_byte_pair.sv
`default_nettype none
// ============================================================================
// Module   : loader_byte_pair
// Purpose  : Joins a hi byte and a following lo byte into a 16-bit word
// Revision : 1.0
// ============================================================================
module loader_byte_pair (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_hi,
    input  logic        load_lo,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        done
);

    logic [7:0] r_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 8'h00;
        end else if (load_hi) begin
            r_hi <= byte_in;
        end
    end

    // word is meaningful only in the cycle done is high (lo byte on byte_in)
    assign word = {r_hi, byte_in};
    assign done = load_lo;

endmodule
`default_nettype wire

// File: rtl/bip_loader.sv
`default_nettype none
// ============================================================================
// Module   : bip_loader
// Purpose  : UART command loader: program/data memory load, run/stop, DM query
// Revision : 1.0
// ============================================================================
module bip_loader
    import bip_loader_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF,
    parameter int ADDR_LENGTH = ADDR_LENGTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_busy,
    input  logic [DATA_LENGTH-1:0] data_from_dm,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   WrPM,
    output logic                   WrDM,
    output logic                   RdDM,
    output logic [DATA_LENGTH-1:0] dataFromInterface,
    output logic [ADDR_LENGTH-1:0] addrFromInterface,
    output logic                   reset_bip,
    output logic                   cmd_err
);

    localparam logic [1:0] TX_SEND  = 2'd0;
    localparam logic [1:0] TX_GAP   = 2'd1;
    localparam logic [1:0] TX_DRAIN = 2'd2;

    logic [STATE_W-1:0]     r_state;
    logic [STATE_W-1:0]     w_next;
    logic [ADDR_LENGTH-1:0] r_count;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic [DATA_LENGTH-1:0] r_data;
    logic [DATA_LENGTH-1:0] r_cap;
    logic [1:0]             r_tx_phase;
    logic                   r_is_prog;
    logic                   r_cmd_err;
    logic                   w_load_hi;
    logic                   w_load_lo;
    logic [15:0]            w_pair_word;
    logic                   w_pair_done;
    logic [15:0]            w_cap16;
    logic                   w_last;
    logic                   w_tx_done;

    loader_byte_pair u_pair (
        .clk     (clk),
        .reset   (reset),
        .load_hi (w_load_hi),
        .load_lo (w_load_lo),
        .byte_in (rx_data),
        .word    (w_pair_word),
        .done    (w_pair_done)
    );

    assign w_cap16   = 16'(r_cap);
    assign w_last    = (r_addr == r_count - ADDR_LENGTH'(1));
    assign w_tx_done = (r_tx_phase == TX_DRAIN) && !tx_busy;

    assign dataFromInterface = r_data;
    assign addrFromInterface = r_addr;
    assign cmd_err           = r_cmd_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_PROG, CMD_DATA: w_next = ST_CNT_HI;
                        CMD_QUERY:          w_next = reset_bip ? ST_A_HI : ST_IDLE;
                        default:            w_next = ST_IDLE;
                    endcase
                end
            end
            ST_CNT_HI: if (rx_valid) w_next = ST_CNT_LO;
            ST_CNT_LO: begin
                if (w_pair_done) begin
                    w_next = (w_pair_word[ADDR_LENGTH-1:0] == '0) ? ST_IDLE : ST_W_HI;
                end
            end
            ST_W_HI:   if (rx_valid) w_next = ST_W_LO;
            ST_W_LO:   if (w_pair_done) w_next = ST_WRITE;
            ST_WRITE:  w_next = w_last ? ST_IDLE : ST_W_HI;
            ST_A_HI:   if (rx_valid) w_next = ST_A_LO;
            ST_A_LO:   if (w_pair_done) w_next = ST_RD;
            ST_RD:     w_next = ST_CAP;
            ST_CAP:    w_next = ST_TX_HI;
            ST_TX_HI:  if (w_tx_done) w_next = ST_TX_LO;
            ST_TX_LO:  if (w_tx_done) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        WrPM      = 1'b0;
        WrDM      = 1'b0;
        RdDM      = 1'b0;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        w_load_hi = 1'b0;
        w_load_lo = 1'b0;
        case (r_state)
            ST_CNT_HI, ST_W_HI, ST_A_HI: w_load_hi = rx_valid;
            ST_CNT_LO, ST_W_LO, ST_A_LO: w_load_lo = rx_valid;
            ST_WRITE: begin
                WrPM = r_is_prog;
                WrDM = !r_is_prog;
            end
            ST_RD: RdDM = 1'b1;
            ST_TX_HI: begin
                tx_data  = w_cap16[15:8];
                tx_start = (r_tx_phase == TX_SEND) && !tx_busy;
            end
            ST_TX_LO: begin
                tx_data  = w_cap16[7:0];
                tx_start = (r_tx_phase == TX_SEND) && !tx_busy;
            end
            default: ;
        endcase
    end

    // Datapath registers; the processor is held (reset_bip=1) out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_cap      <= '0;
            r_tx_phase <= TX_SEND;
            r_is_prog  <= 1'b0;
            r_cmd_err  <= 1'b0;
            reset_bip  <= 1'b1;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_PROG, CMD_DATA: begin
                                r_is_prog <= (rx_data == CMD_PROG);
                                reset_bip <= 1'b1;
                                r_addr    <= '0;
                            end
                            CMD_RUN:   reset_bip <= 1'b0;
                            CMD_STOP:  reset_bip <= 1'b1;
                            CMD_QUERY: r_cmd_err <= !reset_bip;
                            default:   r_cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_CNT_LO: if (w_pair_done) r_count <= w_pair_word[ADDR_LENGTH-1:0];
                ST_W_LO:   if (w_pair_done) r_data <= DATA_LENGTH'(w_pair_word);
                ST_WRITE:  if (!w_last) r_addr <= r_addr + ADDR_LENGTH'(1);
                ST_A_LO:   if (w_pair_done) r_addr <= w_pair_word[ADDR_LENGTH-1:0];
                ST_CAP: begin
                    r_cap      <= data_from_dm;
                    r_tx_phase <= TX_SEND;
                end
                ST_TX_HI, ST_TX_LO: begin
                    case (r_tx_phase)
                        TX_SEND:  if (!tx_busy) r_tx_phase <= TX_GAP;
                        TX_GAP:   r_tx_phase <= TX_DRAIN;
                        default:  if (!tx_busy) r_tx_phase <= TX_SEND;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bip_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_loader
// Purpose  : Directed self-checking bench for bip_loader
// Revision : 1.0
// ============================================================================
module tb_bip_loader;

    localparam int DW = 16;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_busy = 1'b0;
    logic [DW-1:0] data_from_dm = '0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          WrPM, WrDM, RdDM;
    logic [DW-1:0] dataFromInterface;
    logic [AW-1:0] addrFromInterface;
    logic          reset_bip;
    logic          cmd_err;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] pm_addr_q[$];
    logic [DW-1:0] pm_data_q[$];
    logic [AW-1:0] rd_addr_q[$];
    logic [7:0]    tx_q[$];
    logic [DW-1:0] dm [0:(1<<AW)-1];
    int            wrdm_n = 0;
    int            err_pulses = 0;
    int            err_cycles = 0;
    int            tx_overlap = 0;
    logic          prev_err = 1'b0;

    bip_loader dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .tx_busy           (tx_busy),
        .data_from_dm      (data_from_dm),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .WrPM              (WrPM),
        .WrDM              (WrDM),
        .RdDM              (RdDM),
        .dataFromInterface (dataFromInterface),
        .addrFromInterface (addrFromInterface),
        .reset_bip         (reset_bip),
        .cmd_err           (cmd_err)
    );

    always #5 clk = ~clk;

    // Observes strobes on the falling edge and plays the UART transmitter.
    initial begin : monitor
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (WrPM) begin
                pm_addr_q.push_back(addrFromInterface);
                pm_data_q.push_back(dataFromInterface);
            end
            if (WrDM) begin
                wrdm_n++;
                dm[addrFromInterface] = dataFromInterface;
            end
            if (RdDM) rd_addr_q.push_back(addrFromInterface);
            if (cmd_err) begin
                err_cycles++;
                if (!prev_err) err_pulses++;
            end
            prev_err = cmd_err;
            if (tx_start) begin
                tx_q.push_back(tx_data);
                if (tx_busy) tx_overlap++;
                tx_busy  = 1'b1;
                busy_cnt = 4;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    // Data memory with one-cycle synchronous read.
    initial begin : dm_model
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (RdDM) begin
                a = addrFromInterface;
                @(posedge clk);
                #1 data_from_dm = dm[a];
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_logs();
        pm_addr_q.delete();
        pm_data_q.delete();
        rd_addr_q.delete();
        tx_q.delete();
        wrdm_n     = 0;
        err_pulses = 0;
        err_cycles = 0;
        tx_overlap = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (reset_bip !== 1'b1) begin errors++; $display("FAIL reset_bip: got %b want 1", reset_bip); end
        checks++; if ({WrPM, WrDM, RdDM, tx_start, cmd_err} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {WrPM, WrDM, RdDM, tx_start, cmd_err}); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (dataFromInterface !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", dataFromInterface); end
        checks++; if (addrFromInterface !== 11'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", addrFromInterface); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_prog_load();
        clear_logs();
        send_byte(8'h50); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        repeat (3) @(negedge clk);
        checks++; if (pm_addr_q.size() !== 2) begin errors++; $display("FAIL prog_wrpm_count: got %0d want 2", pm_addr_q.size()); end
        checks++; if (pm_addr_q[0] !== 11'd0 || pm_data_q[0] !== 16'h1234) begin errors++; $display("FAIL prog_word0: got %h/%h want 000/1234", pm_addr_q[0], pm_data_q[0]); end
        checks++; if (pm_addr_q[1] !== 11'd1 || pm_data_q[1] !== 16'hABCD) begin errors++; $display("FAIL prog_word1: got %h/%h want 001/abcd", pm_addr_q[1], pm_data_q[1]); end
        checks++; if (wrdm_n !== 0) begin errors++; $display("FAIL prog_no_wrdm: got %0d want 0", wrdm_n); end
        checks++; if (reset_bip !== 1'b1) begin errors++; $display("FAIL prog_reset_bip: got %b want 1", reset_bip); end
    endtask

    task automatic test_zero_count();
        clear_logs();
        send_byte(8'h44); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h52);
        repeat (2) @(negedge clk);
        checks++; if (wrdm_n !== 0) begin errors++; $display("FAIL zero_no_wrdm: got %0d want 0", wrdm_n); end
        checks++; if (reset_bip !== 1'b0) begin errors++; $display("FAIL zero_run_accepted: reset_bip got %b want 0", reset_bip); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL zero_no_err: got %0d want 0", err_pulses); end
    endtask

    task automatic test_query();
        int waited;
        clear_logs();
        send_byte(8'h44); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h07);
        checks++; if (wrdm_n !== 1 || dm[0] !== 16'h0007) begin errors++; $display("FAIL query_dm_write: got %0d/%h want 1/0007", wrdm_n, dm[0]); end
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h00);
        waited = 0;
        while (tx_q.size() < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (waited >= 200) begin errors++; $display("FAIL query_tx_timeout: got %0d bytes want 2", tx_q.size()); end
        checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 11'd0) begin errors++; $display("FAIL query_rddm: got %0d pulses addr %h want 1 at 000", rd_addr_q.size(), rd_addr_q[0]); end
        checks++; if (tx_q[0] !== 8'h00) begin errors++; $display("FAIL query_tx_hi: got %h want 00", tx_q[0]); end
        checks++; if (tx_q[1] !== 8'h07) begin errors++; $display("FAIL query_tx_lo: got %h want 07", tx_q[1]); end
        repeat (10) @(negedge clk);
        checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL query_tx_count: got %0d want 2", tx_q.size()); end
        checks++; if (tx_overlap !== 0) begin errors++; $display("FAIL query_tx_while_busy: got %0d want 0", tx_overlap); end
    endtask

    task automatic test_query_running();
        clear_logs();
        send_byte(8'h52);
        checks++; if (reset_bip !== 1'b0) begin errors++; $display("FAIL run_reset_bip: got %b want 0", reset_bip); end
        send_byte(8'h51);
        repeat (3) @(negedge clk);
        checks++; if (err_pulses !== 1 || err_cycles !== 1) begin errors++; $display("FAIL run_query_err: got %0d pulses %0d cycles want 1/1", err_pulses, err_cycles); end
        checks++; if (rd_addr_q.size() !== 0) begin errors++; $display("FAIL run_query_no_rddm: got %0d want 0", rd_addr_q.size()); end
        send_byte(8'h53);
        checks++; if (reset_bip !== 1'b1) begin errors++; $display("FAIL stop_reset_bip: got %b want 1", reset_bip); end
    endtask

    task automatic test_bad_cmd();
        clear_logs();
        send_byte(8'h7F);
        checks++; if (err_pulses !== 1 || err_cycles !== 1) begin errors++; $display("FAIL bad_cmd_err: got %0d pulses %0d cycles want 1/1", err_pulses, err_cycles); end
        send_byte(8'h52);
        checks++; if (reset_bip !== 1'b0) begin errors++; $display("FAIL bad_cmd_idle: reset_bip got %b want 0", reset_bip); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL bad_cmd_run_no_err: got %0d want 1", err_pulses); end
        send_byte(8'h53);
    endtask

    task automatic test_reset_midload();
        clear_logs();
        send_byte(8'h50); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h11);
        checks++; if (pm_addr_q.size() !== 1 || pm_data_q[0] !== 16'h1111) begin errors++; $display("FAIL midload_first_word: got %0d/%h want 1/1111", pm_addr_q.size(), pm_data_q[0]); end
        @(negedge clk);
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;
        #1;
        checks++; if (reset_bip !== 1'b1 || {WrPM, WrDM, RdDM, tx_start, cmd_err} !== 5'b0) begin errors++; $display("FAIL midload_reset_ctrl: got bip=%b strobes=%b want 1/00000", reset_bip, {WrPM, WrDM, RdDM, tx_start, cmd_err}); end
        checks++; if (dataFromInterface !== 16'h0000 || addrFromInterface !== 11'h000 || tx_data !== 8'h00) begin errors++; $display("FAIL midload_reset_bus: got %h/%h/%h want 0000/000/00", dataFromInterface, addrFromInterface, tx_data); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send_byte(8'h33); send_byte(8'h44);
        repeat (4) @(negedge clk);
        checks++; if (pm_addr_q.size() !== 1) begin errors++; $display("FAIL midload_no_more_wrpm: got %0d want 1", pm_addr_q.size()); end
        checks++; if (addrFromInterface !== 11'h000) begin errors++; $display("FAIL midload_addr_after: got %h want 000", addrFromInterface); end
    endtask

    initial begin
        test_reset();
        test_prog_load();
        test_zero_count();
        test_query();
        test_query_running();
        test_bad_cmd();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
